// File: rtl/page_bridge_pkg.sv
// Shared definitions for the page port bridge: FSM state encoding and a
// constant-evaluable ceil(log2) helper used to size FIFO pointers/counters.
package page_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } bridge_state_e;

  // ceil(log2(value)); clog2(1) = 0
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/page_port_fifo.sv
// Single-clock FIFO for one bridge port. DEPTH must be a power of two so the
// pointers wrap naturally; full/empty come from an occupancy count one bit
// wider than the pointers. The head word is read straight from the storage
// registers, and the output reads zero whenever the FIFO is empty.
module page_port_fifo
  import page_bridge_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage write: only the addressed entry changes on an accepted push.
  // NOTE: the data array has no reset; pointers and count define validity, so
  // resetting the storage would only add reset fan-out for no behavioural gain.
  always_ff @(posedge ap_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; clear empties the FIFO in one cycle.
  // NOTE: non-blocking assignments keep every register update using the
  // pre-edge values, so count and pointers stay mutually consistent.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/page_port_bridge.sv
// Bridge between leaf vld/ack interfaces and kernel AXI-stream ports, with
// one FIFO per port in each direction and a small IDLE/RUN/FLUSH controller.
// Ports only move data in RUN; FLUSH clears every FIFO for one cycle.
// Optional feature: define PAGE_PORT_BRIDGE_STATS_EN to add beat_cnt, a
// 32-bit wrapping count of kernel-side transfers per port (in ports first).
module page_port_bridge
  import page_bridge_pkg::*;
#(
  parameter int NUM_IN_PORTS  = 1,
  parameter int NUM_OUT_PORTS = 1,
  parameter int PAYLOAD_BITS  = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                  ap_clk,
  input  logic                                  ap_rst_n,
  input  logic                                  enable,
  input  logic                                  resend,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  iface_dout,
  input  logic [NUM_IN_PORTS-1:0]               iface_vld,
  output logic [NUM_IN_PORTS-1:0]               iface_ack,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  in_tdata,
  output logic [NUM_IN_PORTS-1:0]               in_tvalid,
  input  logic [NUM_IN_PORTS-1:0]               in_tready,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] out_tdata,
  input  logic [NUM_OUT_PORTS-1:0]              out_tvalid,
  output logic [NUM_OUT_PORTS-1:0]              out_tready,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] iface_din,
  output logic [NUM_OUT_PORTS-1:0]              iface_uvld,
  input  logic [NUM_OUT_PORTS-1:0]              iface_uack,
  output logic                                  ap_start,
  output logic [1:0]                            state_o
`ifdef PAGE_PORT_BRIDGE_STATS_EN
  ,
  output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*32-1:0] beat_cnt
`endif
);

  bridge_state_e state;
  bridge_state_e state_next;
  logic          run;
  logic          flush;

  logic [NUM_IN_PORTS-1:0]  in_full;
  logic [NUM_IN_PORTS-1:0]  in_empty;
  logic [NUM_OUT_PORTS-1:0] out_full;
  logic [NUM_OUT_PORTS-1:0] out_empty;

  assign run      = (state == RUN);
  assign flush    = (state == FLUSH);
  assign ap_start = run;
  assign state_o  = state;

  // Handshakes: ready depends only on FIFO space, valid only on FIFO content,
  // and both are held low outside RUN so nothing moves in IDLE or FLUSH.
  assign iface_ack  = {NUM_IN_PORTS{run}}  & ~in_full;
  assign in_tvalid  = {NUM_IN_PORTS{run}}  & ~in_empty;
  assign out_tready = {NUM_OUT_PORTS{run}} & ~out_full;
  assign iface_uvld = {NUM_OUT_PORTS{run}} & ~out_empty;

  // Controller state register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_next;
  end

  // Next-state logic: resend overrides everything, FLUSH always returns to IDLE.
  // NOTE: state_next gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    if (resend) begin
      state_next = FLUSH;
    end else begin
      case (state)
        IDLE:    if (enable)  state_next = RUN;
        RUN:     if (!enable) state_next = IDLE;
        FLUSH:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
    page_port_fifo #(
      .WIDTH (PAYLOAD_BITS),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .clear    (flush),
      .push     (iface_vld[i] && iface_ack[i]),
      .pop      (in_tvalid[i] && in_tready[i]),
      .din      (iface_dout[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .dout     (in_tdata[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .full     (in_full[i]),
      .empty    (in_empty[i])
    );
  end

  for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
    page_port_fifo #(
      .WIDTH (PAYLOAD_BITS),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .clear    (flush),
      .push     (out_tvalid[j] && out_tready[j]),
      .pop      (iface_uvld[j] && iface_uack[j]),
      .din      (out_tdata[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .dout     (iface_din[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .full     (out_full[j]),
      .empty    (out_empty[j])
    );
  end

`ifdef PAGE_PORT_BRIDGE_STATS_EN
  localparam int NUM_PORTS = NUM_IN_PORTS + NUM_OUT_PORTS;

  logic [NUM_PORTS-1:0] kernel_xfer;

  assign kernel_xfer = {out_tvalid & out_tready, in_tvalid & in_tready};

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_stats
    logic [31:0] cnt;

    // Per-port beat counter; survives FLUSH, cleared only by reset.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)          cnt <= '0;
      else if (kernel_xfer[k]) cnt <= cnt + 32'd1;
    end

    assign beat_cnt[k*32 +: 32] = cnt;
  end
`else
  // Statistics disabled: no beat_cnt port and no counters.
`endif

endmodule
